// File: rtl/capp_pkg.sv
// rtl/capp_pkg.sv - shared op/state types and key/mask line encoding for the CAM sequencer
package capp_pkg;

    localparam int CAPP_WORD_W = 32;

    typedef enum logic [1:0] {
        OP_SEARCH     = 2'd0,
        OP_READ_NEXT  = 2'd1,
        OP_WRITE_RESP = 2'd2,
        OP_CLEAR_RESP = 2'd3
    } capp_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_WRITE,
        ST_RESP
    } capp_state_e;

    // Search pairs flag rows holding the opposite value; write pairs name the value to store.
    function automatic logic [2*CAPP_WORD_W-1:0] capp_line_enc(
        input logic [CAPP_WORD_W-1:0] key,
        input logic [CAPP_WORD_W-1:0] mask,
        input logic                   for_write
    );
        logic [2*CAPP_WORD_W-1:0] lines;
        lines = '0;
        for (int j = 0; j < CAPP_WORD_W; j++) begin
            lines[2*j]   = mask[j] & (key[j] ^ for_write);
            lines[2*j+1] = mask[j] & ~(key[j] ^ for_write);
        end
        return lines;
    endfunction

endpackage

// File: rtl/capp_search_ctrl_if.sv
// rtl/capp_search_ctrl_if.sv - host command/response bundle; rsp_count exists with CAPP_RESP_COUNT_EN
interface capp_search_ctrl_if
    import capp_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 7
);
    logic              cmd_valid;
    logic              cmd_ready;
    capp_op_e          cmd_op;
    logic [WORD_W-1:0] cmd_key;
    logic [WORD_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [IDX_W-1:0]  rsp_index;
    logic [WORD_W-1:0] rsp_data;
`ifdef CAPP_RESP_COUNT_EN
    logic [IDX_W-1:0]  rsp_count;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_index, rsp_data
`ifdef CAPP_RESP_COUNT_EN
        , input rsp_count
`endif
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_index, rsp_data
`ifdef CAPP_RESP_COUNT_EN
        , output rsp_count
`endif
    );

endinterface

// File: rtl/capp_prio_enc.sv
// rtl/capp_prio_enc.sv - combinational lowest-index priority encoder over the responder vector
module capp_prio_enc #(
    parameter int N     = 100,
    parameter int IDX_W = 7
) (
    input  logic [N-1:0]     vec,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        // Two's complement isolates the lowest set bit.
        onehot = vec & (~vec + {{(N-1){1'b0}}, 1'b1});
    end

endmodule

// File: rtl/capp_search_ctrl.sv
// rtl/capp_search_ctrl.sv - CAM array search/read/write sequencer; CAPP_RESP_COUNT_EN adds rsp_count
module capp_search_ctrl
    import capp_pkg::*;
#(
    parameter int NUM_WORDS     = 100,
    parameter int WORD_W        = CAPP_WORD_W,
    parameter int IDX_W         = 7,
    parameter int SETTLE_CYCLES = 2,
    parameter int WRITE_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    capp_search_ctrl_if.slave     host,
    output logic [2*WORD_W-1:0]   mismatch_lines,
    output logic [2*WORD_W-1:0]   write_lines,
    output logic [NUM_WORDS-1:0]  row_sel,
    input  logic [NUM_WORDS-1:0]  array_mismatch,
    input  logic [WORD_W-1:0]     array_read
);

    capp_state_e          state_q, state_d;
    capp_op_e             op_q;
    logic [WORD_W-1:0]    key_q, mask_q;
    logic [7:0]           cnt_q;
    logic [NUM_WORDS-1:0] resp_q;
    logic [NUM_WORDS-1:0] mm_snap_q;
    logic [WORD_W-1:0]    rd_snap_q;
    logic                 rsp_hit_q;
    logic [IDX_W-1:0]     rsp_index_q;
    logic [WORD_W-1:0]    rsp_data_q;

    logic                 resp_any;
    logic [IDX_W-1:0]     low_idx;
    logic [NUM_WORDS-1:0] low_oh;
    logic                 accept;
    logic                 drive_done;
    logic                 write_done;

    capp_prio_enc #(.N(NUM_WORDS), .IDX_W(IDX_W)) u_prio (
        .vec    (resp_q),
        .any    (resp_any),
        .idx    (low_idx),
        .onehot (low_oh)
    );

    assign accept     = host.cmd_valid && (state_q == ST_IDLE);
    assign drive_done = (cnt_q == 8'(SETTLE_CYCLES - 1));
    assign write_done = (cnt_q == 8'(WRITE_CYCLES - 1));

    assign host.rsp_hit   = rsp_hit_q;
    assign host.rsp_index = rsp_index_q;
    assign host.rsp_data  = rsp_data_q;

`ifdef CAPP_RESP_COUNT_EN
    logic [IDX_W-1:0] count_q;

    function automatic logic [IDX_W-1:0] popcount(input logic [NUM_WORDS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (v[i]) n++;
        end
        return IDX_W'(n);
    endfunction

    assign host.rsp_count = count_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (host.cmd_op)
                        OP_SEARCH:     state_d = ST_DRIVE;
                        OP_READ_NEXT:  state_d = resp_any ? ST_DRIVE : ST_RESP;
                        OP_WRITE_RESP: state_d = ST_WRITE;
                        default:       state_d = ST_RESP;
                    endcase
                end
            end
            ST_DRIVE:  if (drive_done) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_RESP;
            ST_WRITE:  if (write_done) state_d = ST_RESP;
            ST_RESP:   if (host.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Lines decode from state, so an asynchronous reset drops them without waiting for a clock.
    always_comb begin
        host.cmd_ready = (state_q == ST_IDLE);
        host.rsp_valid = (state_q == ST_RESP);
        mismatch_lines = '0;
        write_lines    = '0;
        row_sel        = '0;
        if (state_q == ST_DRIVE) begin
            if (op_q == OP_SEARCH) mismatch_lines = capp_line_enc(key_q, mask_q, 1'b0);
            else                   row_sel        = low_oh;
        end
        if (state_q == ST_WRITE) begin
            write_lines = capp_line_enc(key_q, mask_q, 1'b1);
            row_sel     = resp_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_SEARCH;
            key_q       <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            resp_q      <= '0;
            mm_snap_q   <= '0;
            rd_snap_q   <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
`ifdef CAPP_RESP_COUNT_EN
            count_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q        <= host.cmd_op;
                        key_q       <= host.cmd_key;
                        mask_q      <= host.cmd_mask;
                        cnt_q       <= '0;
                        rsp_hit_q   <= 1'b0;
                        rsp_index_q <= '0;
                        rsp_data_q  <= '0;
`ifdef CAPP_RESP_COUNT_EN
                        count_q     <= '0;
`endif
                        if (host.cmd_op == OP_CLEAR_RESP) resp_q <= '0;
                    end
                end
                ST_DRIVE: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Array outputs are taken after the lines have been held the full settle time.
                    if (drive_done) begin
                        mm_snap_q <= array_mismatch;
                        rd_snap_q <= array_read;
                    end
                end
                ST_SAMPLE: begin
                    if (op_q == OP_SEARCH) begin
                        resp_q    <= ~mm_snap_q;
                        rsp_hit_q <= |(~mm_snap_q);
`ifdef CAPP_RESP_COUNT_EN
                        count_q   <= popcount(~mm_snap_q);
`endif
                    end else begin
                        resp_q      <= resp_q & ~low_oh;
                        rsp_hit_q   <= 1'b1;
                        rsp_index_q <= low_idx;
                        rsp_data_q  <= rd_snap_q;
`ifdef CAPP_RESP_COUNT_EN
                        count_q     <= popcount(resp_q & ~low_oh);
`endif
                    end
                end
                ST_WRITE: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (write_done) begin
                        rsp_hit_q <= resp_any;
`ifdef CAPP_RESP_COUNT_EN
                        count_q   <= popcount(resp_q);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
